// File: rtl/led_sequencer_if.sv
// LED sequencer control/status bundle.
// master drives MODE/SPEED/RUN/STEP; slave returns LEDS/TICK/RUNNING.
interface led_sequencer_if;
  logic [1:0] MODE;
  logic [1:0] SPEED;
  logic       RUN;
  logic       STEP;
  logic [7:0] LEDS;
  logic       TICK;
  logic       RUNNING;

  modport master (
    output MODE, SPEED, RUN, STEP,
    input  LEDS, TICK, RUNNING
  );

  modport slave (
    input  MODE, SPEED, RUN, STEP,
    output LEDS, TICK, RUNNING
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled free-run or single-step advance.
// Ports: CLK, RST (async high), io (slave): MODE SPEED RUN STEP -> LEDS TICK RUNNING.
module led_sequencer #(
  parameter logic [31:0] BASE_LIMIT = 32'd50000000
) (
  input logic            CLK,
  input logic            RST,
  led_sequencer_if.slave io
);

  typedef enum logic {S_STOP, S_RUN} state_e;
  typedef enum logic [1:0] {
    M_UP  = 2'b00,
    M_DN  = 2'b01,
    M_ROT = 2'b10,
    M_BNC = 2'b11
  } mode_e;
  typedef enum logic {D_LEFT, D_RIGHT} dir_e;

  state_e      state_q, state_n;
  mode_e       mode_q, mode_n;
  dir_e        dir_q, dir_n, bdir;
  logic [31:0] cnt_q, cnt_n;
  logic [7:0]  leds_q, leds_n, pat;
  logic        tick_q, tick_n;
  logic        step_q;
  logic        run_q;

  logic [31:0] limit;
  logic        hit, rise, chg, adv;

  assign limit = BASE_LIMIT >> io.SPEED;
  // >= rather than == so a lowered limit never lets cnt wrap
  assign hit   = (state_q == S_RUN) && (cnt_q >= limit);
  assign rise  = (state_q == S_STOP) && io.STEP && !step_q;
  assign chg   = (mode_e'(io.MODE) != mode_q);
  assign adv   = !chg && (hit || rise);

  always_comb begin
    pat  = leds_q;
    bdir = dir_q;
    unique case (mode_q)
      M_UP:  pat = leds_q + 8'd1;
      M_DN:  pat = leds_q - 8'd1;
      M_ROT: pat = {leds_q[6:0], leds_q[7]};
      M_BNC: begin
        if (dir_q == D_LEFT) begin
          if (leds_q == 8'h80) begin
            pat  = 8'h40;
            bdir = D_RIGHT;
          end else begin
            pat = leds_q << 1;
          end
        end else begin
          if (leds_q == 8'h01) begin
            pat  = 8'h02;
            bdir = D_LEFT;
          end else begin
            pat = leds_q >> 1;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_n = io.RUN ? S_RUN : S_STOP;
    mode_n  = mode_q;
    dir_n   = dir_q;
    leds_n  = leds_q;
    tick_n  = 1'b0;
    cnt_n   = 32'd0;
    if (state_q == S_RUN && !hit)
      cnt_n = cnt_q + 32'd1;
    if (chg) begin
      mode_n = mode_e'(io.MODE);
      dir_n  = D_LEFT;
      cnt_n  = 32'd0;
      unique case (mode_e'(io.MODE))
        M_UP:  leds_n = 8'h00;
        M_DN:  leds_n = 8'hFF;
        M_ROT: leds_n = 8'h01;
        M_BNC: leds_n = 8'h01;
      endcase
    end else if (adv) begin
      leds_n = pat;
      dir_n  = bdir;
      tick_n = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_STOP;
      mode_q  <= M_UP;
      dir_q   <= D_LEFT;
      cnt_q   <= 32'd0;
      leds_q  <= 8'h00;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      step_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
      leds_q  <= leds_n;
      tick_q  <= tick_n;
      run_q   <= (state_n == S_RUN);
      step_q  <= io.STEP;
    end
  end

  assign io.LEDS    = leds_q;
  assign io.TICK    = tick_q;
  assign io.RUNNING = run_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with BASE_LIMIT=3.
// Hand-computed LEDS/TICK/RUNNING expectations checked by assertions.
module tb_led_sequencer;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ticks;

  led_sequencer_if io ();

  led_sequencer #(.BASE_LIMIT(32'd3)) dut (
    .CLK (CLK),
    .RST (RST),
    .io  (io.slave)
  );

  always #5 CLK = ~CLK;

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // three idle edges, then an advance edge
  task automatic adv_wait(input string tag, input logic [7:0] exp);
    for (int k = 0; k < 3; k++) begin
      clk1();
      chk({tag, "_idle_tick"}, 32'(io.TICK), 32'd0);
    end
    clk1();
    chk({tag, "_tick"}, 32'(io.TICK), 32'd1);
    chk({tag, "_leds"}, 32'(io.LEDS), 32'(exp));
  endtask

  logic [7:0] bnc [15];

  initial begin
    bnc = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    RST = 1'b1;
    io.MODE = 2'd0; io.SPEED = 2'd0; io.RUN = 1'b0; io.STEP = 1'b0;
    clk1(); clk1();
    chk("rst_leds", 32'(io.LEDS), 32'h00);
    chk("rst_tick", 32'(io.TICK), 32'd0);
    chk("rst_running", 32'(io.RUNNING), 32'd0);

    // count up with wrap
    RST = 1'b0; io.RUN = 1'b1;
    clk1();
    chk("up_running", 32'(io.RUNNING), 32'd1);
    chk("up_start", 32'(io.LEDS), 32'h00);
    for (int i = 1; i <= 256; i++)
      adv_wait("up", 8'(i));

    // bounce
    io.MODE = 2'd3;
    clk1();
    chk("bnc_init", 32'(io.LEDS), 32'h01);
    chk("bnc_init_tick", 32'(io.TICK), 32'd0);
    for (int i = 0; i < 15; i++)
      adv_wait("bnc", bnc[i]);

    // mode change mid-count: up, cnt=2, then rotate
    io.MODE = 2'd0;
    clk1();
    chk("up2_init", 32'(io.LEDS), 32'h00);
    clk1(); clk1();
    io.MODE = 2'd2;
    clk1();
    chk("rot_init", 32'(io.LEDS), 32'h01);
    chk("rot_init_tick", 32'(io.TICK), 32'd0);
    adv_wait("rot", 8'h02);

    // speed raise with cnt=3 pending
    clk1(); clk1(); clk1();
    chk("spd_pend_tick", 32'(io.TICK), 32'd0);
    io.SPEED = 2'd2;
    clk1();
    chk("spd2_a", 32'(io.LEDS), 32'h04);
    chk("spd2_a_tick", 32'(io.TICK), 32'd1);
    clk1(); chk("spd2_b", 32'(io.LEDS), 32'h08);
    clk1(); chk("spd2_c", 32'(io.LEDS), 32'h10);
    clk1(); chk("spd2_d", 32'(io.LEDS), 32'h20);
    io.SPEED = 2'd3;
    clk1(); chk("spd3_a", 32'(io.LEDS), 32'h40);
    clk1();
    chk("spd3_b", 32'(io.LEDS), 32'h80);
    chk("spd3_b_tick", 32'(io.TICK), 32'd1);

    // stop; count down by STEP
    io.RUN = 1'b0; io.SPEED = 2'd0;
    clk1();
    chk("stop_running", 32'(io.RUNNING), 32'd0);
    chk("stop_tick", 32'(io.TICK), 32'd0);
    chk("stop_leds", 32'(io.LEDS), 32'h80);
    io.MODE = 2'd1;
    clk1();
    chk("dn_init", 32'(io.LEDS), 32'hFF);
    ticks = 0;
    for (int i = 0; i < 3; i++) begin
      io.STEP = 1'b1;
      clk1();
      ticks += int'(io.TICK);
      chk("step_leds", 32'(io.LEDS), 32'(8'hFE - 8'(i)));
      io.STEP = 1'b0;
      clk1();
      ticks += int'(io.TICK);
    end
    io.STEP = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clk1();
      ticks += int'(io.TICK);
      chk("step_held", 32'(io.LEDS), 32'hFB);
    end
    io.STEP = 1'b0;
    clk1();
    chk("step_ticks", 32'(ticks), 32'd4);

    // RUN falls on the advance edge; STEP in RUN ignored
    io.RUN = 1'b1;
    clk1();
    chk("rerun_running", 32'(io.RUNNING), 32'd1);
    clk1(); clk1(); clk1();
    io.RUN = 1'b0; io.STEP = 1'b1;
    clk1();
    chk("fall_leds", 32'(io.LEDS), 32'hFA);
    chk("fall_tick", 32'(io.TICK), 32'd1);
    chk("fall_running", 32'(io.RUNNING), 32'd0);
    clk1();
    chk("fall_after_leds", 32'(io.LEDS), 32'hFA);
    chk("fall_after_tick", 32'(io.TICK), 32'd0);
    io.STEP = 1'b0;

    // async reset between edges, then re-init to down
    io.RUN = 1'b1;
    clk1(); clk1(); clk1(); clk1();
    #2 RST = 1'b1;
    #1;
    chk("arst_leds", 32'(io.LEDS), 32'h00);
    chk("arst_running", 32'(io.RUNNING), 32'd0);
    chk("arst_tick", 32'(io.TICK), 32'd0);
    #2 RST = 1'b0;
    clk1();
    chk("rel_leds", 32'(io.LEDS), 32'hFF);
    chk("rel_tick", 32'(io.TICK), 32'd0);
    chk("rel_running", 32'(io.RUNNING), 32'd1);
    adv_wait("rel", 8'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
- REQ-001 The block SHALL have parameter BASE_LIMIT, default 50000000, 32-bit terminal count of the tick prescaler at SPEED=0.
- REQ-002 The block SHALL have port CLK, input, 1 bit, the single system clock; all state changes on its rising edge.
- REQ-003 The block SHALL have port RST, input, 1 bit, asynchronous active-high reset.
- REQ-004 The block SHALL have port MODE, input, 2 bits, pattern select: 00 count up, 01 count down, 10 rotate left, 11 bounce.
- REQ-005 The block SHALL have port SPEED, input, 2 bits, prescaler divide select.
- REQ-006 The block SHALL have port RUN, input, 1 bit, level: 1 free-run, 0 stopped.
- REQ-007 The block SHALL have port STEP, input, 1 bit, single-advance request, rising-edge sensitive, honoured only when stopped.
- REQ-008 The block SHALL have port LEDS, output, 8 bits, registered pattern value.
- REQ-009 The block SHALL have port TICK, output, 1 bit, registered one-cycle pulse on every pattern advance.
- REQ-010 The block SHALL have port RUNNING, output, 1 bit, registered, 1 in state RUN.

Function
- REQ-011 The active limit SHALL be BASE_LIMIT >> SPEED, re-evaluated every cycle; 32-bit prescaler cnt.
- REQ-012 FSM SHALL have exactly two states, STOP and RUN; STOP->RUN when RUN=1, RUN->STOP when RUN=0, evaluated every edge.
- REQ-013 In RUN, when cnt >= limit, cnt SHALL clear to 0 and the pattern SHALL advance at that edge; otherwise cnt SHALL increment (period limit+1 cycles).
- REQ-014 In STOP, cnt SHALL be held at 0 and LEDS held; no free-running advances.
- REQ-015 In STOP, a STEP 0->1 transition (STEP high this edge, low previous edge) SHALL advance the pattern once at that edge; STEP held high SHALL yield one advance only; STEP in RUN SHALL be ignored.
- REQ-016 TICK SHALL be 1 in exactly the cycle after each advance edge, coincident with the new LEDS value, else 0.
- REQ-017 Advance rules: up LEDS+1 mod 256; down LEDS-1 mod 256; rotate {LEDS[6:0],LEDS[7]}.
- REQ-018 Bounce SHALL keep internal dir bit: left shifts left, right shifts right; at LEDS=0x80 with dir left, next SHALL be 0x40 and dir right; at 0x01 with dir right, next 0x02 and dir left.
- REQ-019 When MODE differs from the registered mode, at that edge the block SHALL register MODE, load init pattern (up 0x00, down 0xFF, rotate 0x01, bounce 0x01 dir left), clear cnt, and SHALL NOT assert TICK; this takes precedence over tick and STEP in the same cycle.
- REQ-020 Simultaneous RUN 1->0 and cnt >= limit SHALL still advance at that edge (RUN-state decision uses current state), then enter STOP.
- REQ-021 SPEED lowered so cnt exceeds the new limit SHALL cause an advance on the next edge, not a 2^32 wrap.

Reset
- REQ-022 While RST=1, immediately and without clock: LEDS=0x00, TICK=0, RUNNING=0, state STOP, cnt=0, registered mode=00, dir left, STEP history=1 (no spurious step after release).
- REQ-023 After RST release with MODE!=00, the first edge SHALL apply REQ-019 initialisation.
- REQ-024 RST asserted mid-operation SHALL abort any pending advance; no TICK in the cycle after release.

Verification (BASE_LIMIT=3)
- REQ-025 MODE=00, SPEED=0, RUN=1 after reset -> LEDS 00,01,02,... every 4 cycles, TICK each update, 0xFF->0x00 wrap.
- REQ-026 MODE=11, SPEED=0, RUN=1 -> 01,02,04,...,80,40,20,...,01,02.
- REQ-027 RUN=0, MODE=01, STEP pulsed 3 times plus once held 5 cycles -> LEDS FF,FE,FD,FC,FB, exactly 4 TICKs.
- REQ-028 MODE=00 running, cnt=2, MODE->10 -> next cycle LEDS=0x01, cnt=0, TICK=0; next advance 0x02 after 4 cycles.
- REQ-029 SPEED=0 with cnt=3 pending, switch SPEED=2 (limit 0) -> tick every cycle; SPEED=3 (limit 0) identical.
- REQ-030 RST pulsed between clock edges mid-run -> LEDS=0x00 and RUNNING=0 before the next edge; no TICK after release.
